sw_press_classifier: RTL and testbench
======================================

Name: sw_press_classifier

Overview:
- Sits directly downstream of the per-switch chattering filter.
- Consumes one filtered, active-high switch level and classifies each press as a short press, a long press or an auto-repeat.
- Emits single-cycle event pulses for the LED counter and the mode-select logic.
- One instance per switch. The block has its own internal sample-tick prescaler.

Parameters:
- TICK_DIV, 500000: CLK cycles per hold-time tick (10 ms at 50 MHz); must be ≥2.
- LONG_TICKS, 100: ticks of continuous hold before a press is classified long; must be ≥2.
- REPEAT_TICKS, 20: ticks between auto-repeat pulses once long; must be ≥1.

Ports:
- CLK  in  1  system clock; all logic on posedge.
- RST  in  1  reset, synchronous, active-high.
- SW_FILT  in  1  filtered switch level from the chattering filter; 1 = pressed.
- SHORT_P  out  1  one-cycle pulse: released before the long threshold.
- LONG_P  out  1  one-cycle pulse: long threshold reached while still held.
- REPEAT_P  out  1  one-cycle pulse: every REPEAT_TICKS ticks after LONG_P while still held.
- HELD  out  1  level: 1 while in PRESSED or REPEAT.

Behaviour:
- One clock, CLK. Reset is synchronous, active-high on RST. All outputs are registered.
- Reset values:
  - SHORT_P, LONG_P, REPEAT_P, HELD = 0.
  - State = RELEASE; all counters = 0.
- Tick prescaler:
  - tick_cnt counts 0..TICK_DIV-1 and wraps; width $clog2(TICK_DIV).
  - tick = 1 for exactly one cycle when tick_cnt == TICK_DIV-1.
  - Free-running; cleared only by RST. State changes do not restart it.
- hold_cnt: width $clog2(LONG_TICKS+1). rep_cnt: width $clog2(REPEAT_TICKS+1). Neither counter ever wraps.
- FSM states and transitions:
  - RELEASE: wait for SW_FILT = 0, then go to IDLE. This stops a switch that is already held at reset from producing events.
  - IDLE: if SW_FILT = 1, go to PRESSED and set hold_cnt = 0.
  - PRESSED, release wins:
    - SW_FILT = 0: pulse SHORT_P and go to IDLE. This applies even if a tick in the same cycle would reach the threshold.
    - Else, on tick: hold_cnt++. If hold_cnt == LONG_TICKS-1 before the increment, pulse LONG_P, set rep_cnt = 0 and go to REPEAT.
  - REPEAT:
    - SW_FILT = 0: go to IDLE with no pulse, including on a repeat-tick cycle.
    - Else, on tick: if rep_cnt == REPEAT_TICKS-1, pulse REPEAT_P and set rep_cnt = 0; otherwise rep_cnt++.
- Latency:
  - Pulses and HELD change on the CLK edge that registers the state transition, i.e. one cycle after the sampled condition.
  - HELD rises 1 cycle after SW_FILT rises from IDLE.
  - SHORT_P occurs 1 cycle after SW_FILT falls in PRESSED.
- Mutual exclusion: at most one of SHORT_P, LONG_P, REPEAT_P is high in any cycle. Each pulse is exactly 1 cycle wide.
- Press width: a 1-cycle SW_FILT high from IDLE still yields exactly one SHORT_P.
- Back-to-back presses: IDLE re-arms immediately. A new press one cycle after a release is accepted.
- RST mid-press:
  - All pulses drop the next cycle and the state goes to RELEASE.
  - The held switch produces no events until it has been seen released.

Test Plan (TICK_DIV=4, LONG_TICKS=5, REPEAT_TICKS=3):
1. RST 2 cycles, SW_FILT=0 → all outputs 0. Hold SW_FILT=1 for 6 cycles, then 0 → HELD high 6 cycles; exactly one SHORT_P, 1 cycle after the fall; no LONG_P.
2. SW_FILT=1 held for 60 cycles →
   - LONG_P once, 18–21 cycles after the rise.
   - REPEAT_P exactly every 12 cycles after LONG_P (first is 12 cycles after).
   - Release → no SHORT_P; HELD falls 1 cycle later.
3. SW_FILT=1 during and after RST → no pulses and HELD=0 until SW_FILT goes 0 then 1. After that the normal short/long sequence applies.
4. Release on the same cycle as the 5th tick in PRESSED (align via a known tick phase after RST) → SHORT_P asserted, LONG_P never.
5. Pulses 1,0,1,0,1 cycle-wise on SW_FILT → three SHORT_P pulses, none overlapping, each 1 cycle wide.
6. Assert RST 3 cycles after LONG_P while held → no further REPEAT_P; state RELEASE; release then re-press behaves as in scenario 1.

Source files
------------

// File: rtl/sw_press_classifier.sv
// Classifies a filtered active-high switch level into short-press, long-press and
// auto-repeat single-cycle pulses, using an internal free-running hold-time tick.
module sw_press_classifier #(
    parameter int TICK_DIV     = 500000,
    parameter int LONG_TICKS   = 100,
    parameter int REPEAT_TICKS = 20
) (
    input  logic CLK,
    input  logic RST,
    input  logic SW_FILT,
    output logic SHORT_P,
    output logic LONG_P,
    output logic REPEAT_P,
    output logic HELD
);

    localparam int TW = $clog2(TICK_DIV);
    localparam int HW = $clog2(LONG_TICKS + 1);
    localparam int RW = $clog2(REPEAT_TICKS + 1);

    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_TICKS - 1);
    localparam logic [RW-1:0] REP_LAST  = RW'(REPEAT_TICKS - 1);

    typedef enum logic [1:0] {
        ST_RELEASE = 2'd0,
        ST_IDLE    = 2'd1,
        ST_PRESSED = 2'd2,
        ST_REPEAT  = 2'd3
    } state_t;

    state_t          state_r;
    logic [TW-1:0]   tick_cnt_r;
    logic [HW-1:0]   hold_cnt_r;
    logic [RW-1:0]   rep_cnt_r;
    logic            tick_s;

    // Tick strobe decoded from the prescaler's terminal count.
    always_comb begin
        tick_s = (tick_cnt_r == TICK_LAST);
    end

    // Free-running prescaler; only reset restarts its phase.
    always_ff @(posedge CLK) begin
        if (RST) begin
            tick_cnt_r <= {TW{1'b0}};
        end else if (tick_s) begin
            tick_cnt_r <= {TW{1'b0}};
        end else begin
            tick_cnt_r <= tick_cnt_r + TW'(1);
        end
    end

    // Press-classification FSM with registered pulses and HELD level.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r    <= ST_RELEASE;
            hold_cnt_r <= {HW{1'b0}};
            rep_cnt_r  <= {RW{1'b0}};
            SHORT_P    <= 1'b0;
            LONG_P     <= 1'b0;
            REPEAT_P   <= 1'b0;
            HELD       <= 1'b0;
        end else begin
            SHORT_P  <= 1'b0;
            LONG_P   <= 1'b0;
            REPEAT_P <= 1'b0;
            case (state_r)
                ST_RELEASE: begin
                    HELD <= 1'b0;
                    if (!SW_FILT) begin
                        state_r <= ST_IDLE;
                    end else begin
                        state_r <= ST_RELEASE;
                    end
                end
                ST_IDLE: begin
                    if (SW_FILT) begin
                        state_r    <= ST_PRESSED;
                        hold_cnt_r <= {HW{1'b0}};
                        HELD       <= 1'b1;
                    end else begin
                        HELD <= 1'b0;
                    end
                end
                ST_PRESSED: begin
                    // Release takes priority over a coincident threshold tick.
                    if (!SW_FILT) begin
                        SHORT_P <= 1'b1;
                        HELD    <= 1'b0;
                        state_r <= ST_IDLE;
                    end else if (tick_s) begin
                        hold_cnt_r <= hold_cnt_r + HW'(1);
                        if (hold_cnt_r == HOLD_LAST) begin
                            LONG_P    <= 1'b1;
                            rep_cnt_r <= {RW{1'b0}};
                            state_r   <= ST_REPEAT;
                        end else begin
                            state_r <= ST_PRESSED;
                        end
                    end else begin
                        state_r <= ST_PRESSED;
                    end
                end
                ST_REPEAT: begin
                    if (!SW_FILT) begin
                        HELD    <= 1'b0;
                        state_r <= ST_IDLE;
                    end else if (tick_s) begin
                        if (rep_cnt_r == REP_LAST) begin
                            REPEAT_P  <= 1'b1;
                            rep_cnt_r <= {RW{1'b0}};
                        end else begin
                            rep_cnt_r <= rep_cnt_r + RW'(1);
                        end
                    end else begin
                        state_r <= ST_REPEAT;
                    end
                end
                default: begin
                    state_r <= ST_RELEASE;
                    HELD    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sw_press_classifier.sv
// Scoreboard bench: a press-level reference model predicts events and HELD per cycle;
// an independent monitor compares DUT outputs against the queued expectations.
module tb_sw_press_classifier;

    localparam int TD = 4;
    localparam int LT = 5;
    localparam int RT = 3;

    localparam int K_SHORT  = 1;
    localparam int K_LONG   = 2;
    localparam int K_REPEAT = 3;

    typedef struct {
        int kind;
        int cyc;
    } ev_t;

    logic CLK;
    logic RST;
    logic SW_FILT;
    logic SHORT_P;
    logic LONG_P;
    logic REPEAT_P;
    logic HELD;

    ev_t evq[$];
    bit  held_q[$];

    int tests = 0;
    int fails = 0;

    int m_cyc = 0;
    int m_p = 0;
    int m_ticks = 0;
    bit m_armed = 1'b0;
    bit m_pressed = 1'b0;
    bit m_long_seen = 1'b0;
    int mon_cyc = 0;

    sw_press_classifier #(
        .TICK_DIV    (TD),
        .LONG_TICKS  (LT),
        .REPEAT_TICKS(RT)
    ) dut (
        .CLK     (CLK),
        .RST     (RST),
        .SW_FILT (SW_FILT),
        .SHORT_P (SHORT_P),
        .LONG_P  (LONG_P),
        .REPEAT_P(REPEAT_P),
        .HELD    (HELD)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic void push_ev(input int kind);
        ev_t e;
        e.kind = kind;
        e.cyc  = m_cyc;
        evq.push_back(e);
    endfunction

    // Drive one cycle and advance the press-level model by the same edge.
    task automatic step(input bit rst, input bit sw);
        bit tick;
        RST     = rst;
        SW_FILT = sw;
        @(posedge CLK);
        m_cyc++;
        if (rst) begin
            m_p       = 0;
            m_armed   = 1'b0;
            m_pressed = 1'b0;
            m_ticks   = 0;
        end else begin
            tick = ((m_p % TD) == TD - 1);
            m_p++;
            if (!m_armed) begin
                if (!sw) m_armed = 1'b1;
            end else if (!m_pressed) begin
                if (sw) begin
                    m_pressed = 1'b1;
                    m_ticks   = 0;
                end
            end else if (!sw) begin
                m_pressed = 1'b0;
                if (m_ticks < LT) push_ev(K_SHORT);
            end else if (tick) begin
                m_ticks++;
                if (m_ticks == LT) begin
                    push_ev(K_LONG);
                    m_long_seen = 1'b1;
                end else if (m_ticks > LT && ((m_ticks - LT) % RT) == 0) begin
                    push_ev(K_REPEAT);
                end
            end
        end
        held_q.push_back(m_pressed);
        #1;
    endtask

    task automatic hold(input bit sw, input int n);
        for (int i = 0; i < n; i++) step(1'b0, sw);
    endtask

    // Monitor: compares HELD every cycle and matches each pulse to the event queue.
    always @(negedge CLK) begin
        int npulse;
        int kind;
        bit exp_held;
        mon_cyc++;
        if (held_q.size() > 0) begin
            exp_held = held_q.pop_front();
            tests++;
            if (HELD !== exp_held) begin
                fails++;
                $display("FAIL held cyc=%0d got=%b exp=%b", mon_cyc, HELD, exp_held);
            end
        end
        while (evq.size() > 0 && evq[0].cyc < mon_cyc) begin
            tests++;
            fails++;
            $display("FAIL missing_pulse cyc=%0d got=none exp=kind%0d@%0d",
                     mon_cyc, evq[0].kind, evq[0].cyc);
            void'(evq.pop_front());
        end
        npulse = 0;
        kind   = 0;
        if (SHORT_P  === 1'b1) begin npulse++; kind = K_SHORT;  end
        if (LONG_P   === 1'b1) begin npulse++; kind = K_LONG;   end
        if (REPEAT_P === 1'b1) begin npulse++; kind = K_REPEAT; end
        if (npulse > 1) begin
            tests++;
            fails++;
            $display("FAIL exclusive cyc=%0d got=%b%b%b exp=one_hot",
                     mon_cyc, SHORT_P, LONG_P, REPEAT_P);
        end else if (npulse == 1) begin
            tests++;
            if (evq.size() == 0 || evq[0].cyc != mon_cyc || evq[0].kind != kind) begin
                fails++;
                $display("FAIL pulse cyc=%0d got=kind%0d exp=%s", mon_cyc, kind,
                         (evq.size() == 0) ? "none" :
                         $sformatf("kind%0d@%0d", evq[0].kind, evq[0].cyc));
            end else begin
                void'(evq.pop_front());
            end
        end
    end

    initial begin
        int guard;
        RST     = 1'b1;
        SW_FILT = 1'b0;

        // Reset, then a 6-cycle short press.
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        hold(1'b0, 3);
        hold(1'b1, 6);
        hold(1'b0, 4);

        // Long hold with auto-repeat, then release.
        hold(1'b1, 60);
        hold(1'b0, 4);

        // Switch held through reset: ignored until seen released.
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        hold(1'b1, 10);
        hold(1'b0, 2);
        hold(1'b1, 5);
        hold(1'b0, 3);
        hold(1'b1, 30);
        hold(1'b0, 3);

        // Release coincident with the 5th tick after a known prescaler phase.
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b1);
        hold(1'b1, 17);
        hold(1'b0, 4);

        // Single-cycle pulses on the switch.
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1);
            step(1'b0, 1'b0);
        end
        hold(1'b0, 3);

        // Reset three cycles after LONG while held.
        m_long_seen = 1'b0;
        guard = 0;
        while (!m_long_seen && guard < 100) begin
            step(1'b0, 1'b1);
            guard++;
        end
        tests++;
        if (!m_long_seen) begin
            fails++;
            $display("FAIL long_wait got=no_long exp=long_within_100");
        end
        hold(1'b1, 3);
        step(1'b1, 1'b1);
        hold(1'b1, 20);
        hold(1'b0, 2);
        hold(1'b1, 6);
        hold(1'b0, 3);

        // Randomized presses, gaps and occasional resets.
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 14) == 0) begin
                for (int j = 0; j < int'($urandom_range(1, 3)); j++)
                    step(1'b1, 1'($urandom_range(0, 1)));
            end
            hold(1'b1, $urandom_range(1, 55));
            hold(1'b0, $urandom_range(1, 6));
        end

        hold(1'b0, 6);
        @(negedge CLK);
        #1;
        tests++;
        if (evq.size() != 0 || held_q.size() != 0) begin
            fails++;
            $display("FAIL drain got=%0d_events_%0d_held exp=0_0", evq.size(), held_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
